writeback_ctrl: RTL and testbench

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/wb_pkg.sv | 23 ++
 rtl/dest_decoder.sv | 22 ++
 rtl/writeback_ctrl.sv | 122 ++++++++++++
 tb/tb_writeback_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_pkg                                                    |
// | Purpose  : Shared widths, buffer depth and entry layout for the      |
// |            writeback controller.                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int DEPTH  = 2;

  // One buffered result: value, destination register index, write enable.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
    logic              wen;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dest_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dest_decoder                                              |
// | Purpose  : Gated one-hot decode of a register index.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dest_decoder #(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_en,
  output logic [NREGS-1:0]  o_onehot
);

  // One comparator per register; all outputs low when disabled.
  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    assign o_onehot[i] = i_en && (i_idx == ADDR_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : writeback_ctrl                                            |
// | Purpose  : Two-entry in-order writeback buffer driving one-hot       |
// |            register load strobes and a shared data bus.              |
// | Options  : STATUS_FLAGS_EN - registered zero/negative flags of the   |
// |            last written value.                                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module writeback_ctrl #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int NREGS  = wb_pkg::NREGS,
  parameter int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic              stall,
  output logic [NREGS-1:0]  load,
  output logic [DATA_W-1:0] wb_data,
  output logic [NREGS-1:0]  busy,
  output logic [1:0]        count,
  output logic              flag_z,
  output logic              flag_n
);

  import wb_pkg::*;

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
    logic              wen;
  } entry_t;

  entry_t     r_entry [DEPTH];
  logic [1:0] r_count;
  logic       w_push;
  logic       w_issue;
  entry_t     w_in;
  logic [NREGS-1:0] w_busy_vec [DEPTH];

  // in_ready is gated by reset so it drops asynchronously with it.
  assign in_ready = reset && (r_count < 2'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_issue  = (r_count != 2'd0) && !stall;
  assign w_in     = '{data: in_data, dest: in_dest, wen: in_wen};

  // FIFO storage and occupancy; entry 0 is always the head.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
      for (int k = 0; k < DEPTH; k++) r_entry[k] <= '0;
    end else begin
      if (w_issue) r_entry[0] <= r_entry[1];
      // Push with a concurrent pop only happens at count 1, so the new
      // entry lands directly in the head slot vacated by the pop.
      if (w_push) begin
        if (w_issue || (r_count == 2'd0)) r_entry[0] <= w_in;
        else                              r_entry[1] <= w_in;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Load strobe is combinational so the register captures at the pop edge.
  dest_decoder #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_load_dec (
    .i_idx    (r_entry[0].dest),
    .i_en     (w_issue && r_entry[0].wen),
    .o_onehot (load)
  );

  // Per-entry pending-write decode; only valid entries with wen contribute.
  for (genvar k = 0; k < DEPTH; k++) begin : g_busy
    dest_decoder #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_busy_dec (
      .i_idx    (r_entry[k].dest),
      .i_en     ((r_count > 2'(k)) && r_entry[k].wen),
      .o_onehot (w_busy_vec[k])
    );
  end

  // OR the per-entry pending masks together.
  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) busy = busy | w_busy_vec[k];
  end

  assign wb_data = (r_count != 2'd0) ? r_entry[0].data : '0;
  assign count   = r_count;

`ifdef STATUS_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  // Capture flags of each written value at its pop edge; hold otherwise.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_issue && r_entry[0].wen) begin
      r_flag_z <= (r_entry[0].data == '0);
      r_flag_n <= r_entry[0].data[DATA_W-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_writeback_ctrl                                         |
// | Purpose  : Self-checking bench for writeback_ctrl (default widths).  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_writeback_ctrl;
  import wb_pkg::*;

  logic              CLK = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_dest;
  logic              in_wen;
  logic              stall;
  logic [NREGS-1:0]  load;
  logic [DATA_W-1:0] wb_data;
  logic [NREGS-1:0]  busy;
  logic [1:0]        count;
  logic              flag_z;
  logic              flag_n;

  writeback_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_wen(in_wen), .stall(stall),
    .load(load), .wb_data(wb_data), .busy(busy), .count(count),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              w;
    logic              s;
    logic [1:0]        cnt;
    logic [NREGS-1:0]  ld;
    logic [DATA_W-1:0] wb;
  } vec_t;

  vec_t      tbl [26];
  wb_entry_t sb [$];
  logic      m_fz = 1'b0;
  logic      m_fn = 1'b0;
  int        n_vec = 0;
  int        n_err = 0;

  function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] a, logic w,
                              logic s, logic [1:0] cnt, logic [3:0] ld, logic [7:0] wb);
    vec_t r;
    r.v = v; r.d = d; r.a = a; r.w = w; r.s = s; r.cnt = cnt; r.ld = ld; r.wb = wb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the scoreboard, then advance it by one edge.
  task automatic model_check_and_advance(input logic v, input logic [7:0] d,
                                         input logic [1:0] a, input logic w, input logic s);
    logic [NREGS-1:0]  e_ld;
    logic [NREGS-1:0]  e_busy;
    logic [DATA_W-1:0] e_wb;
    wb_entry_t         ne;
    int                n;
    n = sb.size();
    e_ld = '0; e_busy = '0; e_wb = '0;
    if (n > 0) begin
      e_wb = sb[0].data;
      if (!s && sb[0].wen) e_ld[sb[0].dest] = 1'b1;
    end
    foreach (sb[k]) if (sb[k].wen) e_busy[sb[k].dest] = 1'b1;
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n < 2));
    chk("load", 32'(load), 32'(e_ld));
    chk("wb_data", 32'(wb_data), 32'(e_wb));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("flag_z", 32'(flag_z), 32'(m_fz));
    chk("flag_n", 32'(flag_n), 32'(m_fn));
    if (n > 0 && !s) begin
`ifdef STATUS_FLAGS_EN
      if (sb[0].wen) begin
        m_fz = (sb[0].data == 8'h00);
        m_fn = sb[0].data[DATA_W-1];
      end
`endif
      void'(sb.pop_front());
    end
    if (v && n < 2) begin
      ne.data = d; ne.dest = a; ne.wen = w;
      sb.push_back(ne);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] a,
                      input logic w, input logic s);
    @(negedge CLK);
    in_valid = v; in_data = d; in_dest = a; in_wen = w; stall = s;
    #1;
    model_check_and_advance(v, d, a, w, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Hand-derived cycle table: inputs for the cycle, outputs seen before its edge.
    tbl[0]  = mk(1, 8'hA5, 2, 1, 0, 0, 4'b0000, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 0, 0, 1, 4'b0100, 8'hA5);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h00);
    tbl[3]  = mk(1, 8'h11, 0, 1, 1, 0, 4'b0000, 8'h00);
    tbl[4]  = mk(1, 8'h22, 3, 1, 1, 1, 4'b0000, 8'h11);
    tbl[5]  = mk(1, 8'h99, 1, 1, 1, 2, 4'b0000, 8'h11);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 2, 4'b0001, 8'h11);
    tbl[7]  = mk(0, 8'h00, 0, 0, 0, 1, 4'b1000, 8'h22);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h00);
    tbl[9]  = mk(1, 8'h11, 1, 1, 1, 0, 4'b0000, 8'h00);
    tbl[10] = mk(1, 8'h22, 1, 1, 0, 1, 4'b0010, 8'h11);
    tbl[11] = mk(1, 8'h33, 2, 1, 0, 1, 4'b0010, 8'h22);
    tbl[12] = mk(0, 8'h00, 0, 0, 0, 1, 4'b0100, 8'h33);
    tbl[13] = mk(0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h00);
    tbl[14] = mk(1, 8'h44, 0, 1, 1, 0, 4'b0000, 8'h00);
    tbl[15] = mk(1, 8'h55, 3, 0, 1, 1, 4'b0000, 8'h44);
    tbl[16] = mk(0, 8'h00, 0, 0, 0, 2, 4'b0001, 8'h44);
    tbl[17] = mk(1, 8'h66, 1, 1, 0, 1, 4'b0000, 8'h55);
    tbl[18] = mk(0, 8'h00, 0, 0, 0, 1, 4'b0010, 8'h66);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h00);
    tbl[20] = mk(1, 8'h00, 0, 1, 0, 0, 4'b0000, 8'h00);
    tbl[21] = mk(1, 8'h80, 1, 1, 0, 1, 4'b0001, 8'h00);
    tbl[22] = mk(0, 8'h00, 0, 0, 1, 1, 4'b0000, 8'h80);
    tbl[23] = mk(0, 8'h00, 0, 0, 1, 1, 4'b0000, 8'h80);
    tbl[24] = mk(0, 8'h00, 0, 0, 0, 1, 4'b0010, 8'h80);
    tbl[25] = mk(0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h00);

    // Reset state while reset is held low.
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; in_wen = 1'b0; stall = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({flag_z, flag_n}), 0);
    @(negedge CLK);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].s);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_load", i), 32'(load), 32'(tbl[i].ld));
      chk($sformatf("tbl%0d_wb_data", i), 32'(wb_data), 32'(tbl[i].wb));
    end

`ifdef STATUS_FLAGS_EN
    chk("flag_z_after_0x80", 32'(flag_z), 0);
    chk("flag_n_after_0x80", 32'(flag_n), 1);
`endif

    // Reset mid-operation with a full buffer and an active load strobe.
    step(1, 8'hC1, 2, 1, 1);
    step(1, 8'hC2, 1, 1, 1);
    @(negedge CLK);
    in_valid = 1'b0; stall = 1'b0;
    #1;
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_load", 32'(load), 32'(4'b0100));
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_load", 32'(load), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    chk("async_rst_wb_data", 32'(wb_data), 0);
    sb.delete();
    m_fz = 1'b0; m_fn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    repeat (3) step(0, 8'h00, 0, 0, 0);

    // Short random burst against the scoreboard.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    repeat (3) step(0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
